// File: rtl/tile_pwr_seq_pkg.sv
// Shared constants for the tile power sequencer: tile count and edge spacing.
package tile_pwr_seq_pkg;

   localparam int unsigned NumClusters      = 15;
   // The SPU tile takes the last index after the clusters.
   localparam int unsigned NumPwrTiles      = NumClusters + 1;
   localparam int unsigned TilePwrGapCycles = 8;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tile_pwr_seq_lzc.sv
// Trailing-zero counter: index of the lowest set bit, plus an all-zero flag.
module tile_pwr_seq_lzc #(
   parameter int unsigned Width = 16,
   parameter int unsigned IdxW  = 4
) (
   input  logic [Width-1:0] bits,
   output logic [IdxW-1:0]  idx,
   output logic             empty
);

   // Descending scan so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      empty = 1'b1;
      for (int i = int'(Width) - 1; i >= 0; i--) begin
         if (bits[i]) begin
            idx   = IdxW'(i);
            empty = 1'b0;
         end
      end
   end

endmodule

// File: rtl/tile_pwr_seq.sv
// Staggered per-tile clock-enable / reset sequencer, one bulk request at a time.
module tile_pwr_seq
   import tile_pwr_seq_pkg::*;
#(
   parameter int unsigned NumTiles  = NumPwrTiles,
   parameter int unsigned GapCycles = TilePwrGapCycles
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [NumTiles-1:0] req_mask_i,
   input  logic                req_on_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [NumTiles-1:0] tile_clk_en_o,
   output logic [NumTiles-1:0] tile_rst_no
);

   localparam int unsigned IdxW = clog2_min1(NumTiles);
   localparam int unsigned CntW = clog2_min1(GapCycles);

   if (GapCycles < 1) begin : gen_bad_gap
      $error("tile_pwr_seq: GapCycles must be at least 1");
   end
   if (NumTiles < 1) begin : gen_bad_tiles
      $error("tile_pwr_seq: NumTiles must be at least 1");
   end

   typedef enum logic [1:0] {
      Idle   = 2'd0,
      PhaseA = 2'd1,
      PhaseB = 2'd2,
      Done   = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [NumTiles-1:0] pending_q, pending_d;
   logic                on_q, on_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [NumTiles-1:0] clk_en_q, clk_en_d;
   logic [NumTiles-1:0] rst_n_q, rst_n_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                go_a, go_b;

   logic [NumTiles-1:0] new_pending;
   logic [NumTiles-1:0] lzc_bits;
   logic [IdxW-1:0]     lzc_idx;
   logic                lzc_empty;
   logic                accept;

   assign accept      = req_valid_i & ready_q;
   // Skip tiles already in the requested state.
   assign new_pending = req_mask_i & (req_on_i ? ~rst_n_q : rst_n_q);
   assign lzc_bits    = (state_q == Idle) ? new_pending : pending_q;

   tile_pwr_seq_lzc #(
      .Width (NumTiles),
      .IdxW  (IdxW)
   ) i_lzc (
      .bits  (lzc_bits),
      .idx   (lzc_idx),
      .empty (lzc_empty)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= Idle;
         cnt_q     <= '0;
         pending_q <= '0;
         on_q      <= 1'b0;
         idx_q     <= '0;
         clk_en_q  <= '0;
         rst_n_q   <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         on_q      <= on_d;
         idx_q     <= idx_d;
         clk_en_q  <= clk_en_d;
         rst_n_q   <= rst_n_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state and sequencing bookkeeping.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      on_d      = on_q;
      idx_d     = idx_q;
      go_a      = 1'b0;
      go_b      = 1'b0;
      unique case (state_q)
         Idle: begin
            if (accept) begin
               on_d      = req_on_i;
               pending_d = new_pending;
               if (lzc_empty) begin
                  state_d = Done;
               end else begin
                  idx_d   = lzc_idx;
                  cnt_d   = CntW'(GapCycles - 1);
                  go_a    = 1'b1;
                  state_d = PhaseA;
               end
            end
         end
         PhaseA: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else begin
               pending_d[idx_q] = 1'b0;
               cnt_d            = CntW'(GapCycles - 1);
               go_b             = 1'b1;
               state_d          = PhaseB;
            end
         end
         PhaseB: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else if (lzc_empty) begin
               state_d = Done;
            end else begin
               idx_d   = lzc_idx;
               cnt_d   = CntW'(GapCycles - 1);
               go_a    = 1'b1;
               state_d = PhaseA;
            end
         end
         Done: begin
            state_d = Idle;
         end
         default: begin
            state_d = Idle;
         end
      endcase
   end

   // Tile edges and status, computed from the next state so they land registered.
   always_comb begin
      clk_en_d = clk_en_q;
      rst_n_d  = rst_n_q;
      if (go_a) begin
         if (on_d) clk_en_d[idx_d] = 1'b1;
         else      rst_n_d[idx_d]  = 1'b0;
      end
      if (go_b) begin
         if (on_q) rst_n_d[idx_q]  = 1'b1;
         else      clk_en_d[idx_q] = 1'b0;
      end
      ready_d = (state_d == Idle);
      busy_d  = (state_d != Idle);
      done_d  = (state_d == Done);
   end

   assign req_ready_o   = ready_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign tile_clk_en_o = clk_en_q;
   assign tile_rst_no   = rst_n_q;

endmodule

// File: tb/tb_tile_pwr_seq.sv
// Directed bench for tile_pwr_seq: per-cycle trace compared against timing formulas.
module tb_tile_pwr_seq;

   localparam int unsigned NT = 16;
   localparam int G = 8;

   logic          clk;
   logic          rst_ni;
   logic          req_valid;
   logic          req_ready;
   logic [NT-1:0] req_mask;
   logic          req_on;
   logic          busy;
   logic          done;
   logic [NT-1:0] tile_clk_en;
   logic [NT-1:0] tile_rst_n;

   int total = 0;
   int bad   = 0;

   logic [NT-1:0] m_clk = '0;
   logic [NT-1:0] m_rst = '0;

   tile_pwr_seq #(
      .NumTiles  (NT),
      .GapCycles (G)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_mask_i    (req_mask),
      .req_on_i      (req_on),
      .busy_o        (busy),
      .done_o        (done),
      .tile_clk_en_o (tile_clk_en),
      .tile_rst_no   (tile_rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Issue a request at the next edge, then compare every cycle to the expected trace.
   // stop_k > 0 ends early after that cycle; hold leaves a follow-up request asserted.
   task automatic run_req(input logic [NT-1:0] mask, input logic on, input int stop_k,
                          input logic hold, input logic [NT-1:0] nmask, input logic non);
      logic [NT-1:0] pend, ec, er;
      int ord[NT];
      int n, last, kmax, a, b;
      pend = mask & (on ? ~m_rst : m_rst);
      n = 0;
      for (int i = 0; i < int'(NT); i++) begin
         if (pend[i]) begin ord[i] = n; n++; end
         else ord[i] = -1;
      end
      last = 2 + 2 * n * G;
      kmax = (stop_k > 0) ? stop_k : last;
      ec = m_clk;
      er = m_rst;
      req_mask  = mask;
      req_on    = on;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      if (hold) begin
         req_mask = nmask;
         req_on   = non;
      end else begin
         req_valid = 1'b0;
      end
      for (int k = 1; k <= kmax; k++) begin
         @(negedge clk);
         ec = m_clk;
         er = m_rst;
         for (int i = 0; i < int'(NT); i++) begin
            if (ord[i] >= 0) begin
               a = 1 + 2 * ord[i] * G;
               b = a + G;
               if (on) begin
                  if (k >= a) ec[i] = 1'b1;
                  if (k >= b) er[i] = 1'b1;
               end else begin
                  if (k >= a) er[i] = 1'b0;
                  if (k >= b) ec[i] = 1'b0;
               end
            end
         end
         chk("clk_en", 32'(tile_clk_en), 32'(ec));
         chk("rst_n",  32'(tile_rst_n),  32'(er));
         chk("done",   32'(done),  32'(k == last - 1));
         chk("ready",  32'(req_ready), 32'(k >= last));
         chk("busy",   32'(busy),  32'(k < last));
         chk("rst_implies_clk", 32'(tile_rst_n & ~tile_clk_en), 32'(0));
      end
      m_clk = ec;
      m_rst = er;
   endtask

   initial begin
      rst_ni    = 1'b0;
      req_valid = 1'b0;
      req_mask  = '0;
      req_on    = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready",  32'(req_ready),   32'(1));
      chk("rst_busy",   32'(busy),        32'(0));
      chk("rst_done",   32'(done),        32'(0));
      chk("rst_clk_en", 32'(tile_clk_en), 32'(0));
      chk("rst_rst_n",  32'(tile_rst_n),  32'(0));
      rst_ni = 1'b1;
      @(negedge clk);

      run_req(16'h0001, 1'b1, 0, 1'b0, '0, 1'b0);   // single tile up
      run_req(16'h0111, 1'b1, 0, 1'b0, '0, 1'b0);   // tiles 4, 8 up (0 already up)
      run_req(16'h0111, 1'b1, 0, 1'b0, '0, 1'b0);   // idempotent: empty pending
      run_req(16'hFFFF, 1'b0, 0, 1'b0, '0, 1'b0);   // partial shutdown of 0, 4, 8
      run_req(16'h0111, 1'b1, 0, 1'b0, '0, 1'b0);   // three tiles up from all-off
      run_req(16'h0111, 1'b0, 0, 1'b0, '0, 1'b0);   // back down

      // Hold a second request while busy; it must be taken on the first ready cycle.
      run_req(16'h0002, 1'b1, 0, 1'b1, 16'h0004, 1'b1);
      run_req(16'h0004, 1'b1, 0, 1'b0, '0, 1'b0);

      // Reset in PHASE_B of tile 4 (cycles t+25..t+32).
      run_req(16'h0111, 1'b1, 28, 1'b0, '0, 1'b0);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_clk_en", 32'(tile_clk_en), 32'(0));
      chk("mid_rst_rst_n",  32'(tile_rst_n),  32'(0));
      chk("mid_rst_ready",  32'(req_ready),   32'(1));
      chk("mid_rst_busy",   32'(busy),        32'(0));
      chk("mid_rst_done",   32'(done),        32'(0));
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 32'(1));
      chk("post_rst_busy",  32'(busy),      32'(0));
      m_clk = '0;
      m_rst = '0;

      run_req(16'h00FF, 1'b0, 0, 1'b0, '0, 1'b0);   // shutdown of already-off tiles
      run_req(16'h8000, 1'b1, 0, 1'b0, '0, 1'b0);   // highest index (SPU tile)

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
